// File: rtl/ysyx_22041211_mem_arbiter_if.sv
// Generic valid/ready memory request/response bus shared by IFU, LSU and the memory port.
// The master drives requests and consumes responses; the slave does the opposite.
`ifndef MEM_MASK_8
`define MEM_MASK_8  8'h01
`endif
`ifndef MEM_MASK_16
`define MEM_MASK_16 8'h03
`endif
`ifndef MEM_MASK_32
`define MEM_MASK_32 8'h0f
`endif

interface ysyx_22041211_mem_arbiter_if #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
);
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_LEN-1:0] addr;
    logic                wen;
    logic [DATA_LEN-1:0] wdata;
    logic [7:0]          mask;
    logic                resp_valid;
    logic                resp_ready;
    logic [DATA_LEN-1:0] rdata;

    modport master (
        output req_valid, addr, wen, wdata, mask, resp_ready,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, mask, resp_ready,
        output req_ready, resp_valid, rdata
    );
endinterface

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Non-pipelined IFU/LSU arbiter in front of the single memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is LSU priority.
//
// state | meaning
// IDLE  | no transaction; grant a requester and latch its request
// REQ   | presenting latched request to memory until mem accepts
// WAIT  | waiting for memory response; captures read data
// RESP  | holding response to the owner until it is consumed
module ysyx_22041211_mem_arbiter #(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic clk,
    input  logic rst,
    ysyx_22041211_mem_arbiter_if.slave  ifu,
    ysyx_22041211_mem_arbiter_if.slave  lsu,
    ysyx_22041211_mem_arbiter_if.master mem,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_LEN-1:0] addr_q;
    logic                wen_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [7:0]          mask_q;
    logic                owner_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic                any_req;
    logic                grant_lsu;
    logic                accept;

    // IFU is read-only, so its write-side bus fields are never looked at.
    logic unused_ifu;
    assign unused_ifu = ^{ifu.wen, ifu.wdata, ifu.mask};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
`endif

    assign any_req = ifu.req_valid | lsu.req_valid;
    assign accept  = (state == IDLE) && any_req;

    always_comb begin
        grant_lsu = 1'b0;
        if (lsu.req_valid && !ifu.req_valid) begin
            grant_lsu = 1'b1;
        end else if (lsu.req_valid && ifu.req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_lsu = (last_grant == OWNER_IFU);
`else
            grant_lsu = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req)                    state_nxt = REQ;
            REQ:  if (mem.req_ready)              state_nxt = WAIT;
            WAIT: if (mem.resp_valid)             state_nxt = RESP;
            RESP: begin
                if ((owner_q == OWNER_LSU) ? lsu.resp_ready : ifu.resp_ready)
                    state_nxt = IDLE;
            end
            default:                              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            mask_q     <= '0;
            owner_q    <= OWNER_IFU;
            rdata_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= OWNER_LSU;
`endif
        end else begin
            if (accept) begin
                owner_q <= grant_lsu;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant <= grant_lsu;
`endif
                if (grant_lsu) begin
                    addr_q  <= lsu.addr;
                    wen_q   <= lsu.wen;
                    wdata_q <= lsu.wdata;
                    mask_q  <= lsu.mask;
                end else begin
                    addr_q  <= ifu.addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    mask_q  <= `MEM_MASK_32;
                end
            end
            if (state == WAIT && mem.resp_valid) begin
                rdata_q <= wen_q ? '0 : mem.rdata;
            end
        end
    end

    // Grants are qualified with rst so a requester held valid during reset sees ready=0.
    always_comb begin
        ifu.req_ready  = 1'b0;
        lsu.req_ready  = 1'b0;
        ifu.resp_valid = 1'b0;
        lsu.resp_valid = 1'b0;
        ifu.rdata      = rdata_q;
        lsu.rdata      = rdata_q;
        mem.req_valid  = 1'b0;
        mem.resp_ready = 1'b0;
        mem.addr       = addr_q;
        mem.wen        = wen_q;
        mem.wdata      = wdata_q;
        mem.mask       = mask_q;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                ifu.req_ready = rst && ifu.req_valid && !grant_lsu;
                lsu.req_ready = rst && grant_lsu;
            end
            REQ:  mem.req_valid  = 1'b1;
            WAIT: mem.resp_ready = 1'b1;
            RESP: begin
                ifu.resp_valid = (owner_q == OWNER_IFU);
                lsu.resp_valid = (owner_q == OWNER_LSU);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: vector table plus stall, backpressure
// and mid-transaction reset sequences. Expected owners follow ARB_ROUND_ROBIN_EN.
module tb_ysyx_22041211_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ysyx_22041211_mem_arbiter_if ifu_bus ();
    ysyx_22041211_mem_arbiter_if lsu_bus ();
    ysyx_22041211_mem_arbiter_if mem_bus ();

    ysyx_22041211_mem_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .ifu  (ifu_bus),
        .lsu  (lsu_bus),
        .mem  (mem_bus),
        .busy (busy)
    );

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] lsu_wdata;
        logic [7:0]  lsu_mask;
        logic [31:0] mem_rdata;
        logic        exp_lsu;
        logic [31:0] exp_addr;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_mask;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        ifu_bus.req_valid = v.ifu_v;
        ifu_bus.addr      = v.ifu_addr;
        lsu_bus.req_valid = v.lsu_v;
        lsu_bus.addr      = v.lsu_addr;
        lsu_bus.wen       = v.lsu_wen;
        lsu_bus.wdata     = v.lsu_wdata;
        lsu_bus.mask      = v.lsu_mask;
        mem_bus.rdata     = v.mem_rdata;
        @(negedge clk);
        chk({p, "_ifu_req_ready"}, 64'(ifu_bus.req_ready), 64'(!v.exp_lsu));
        chk({p, "_lsu_req_ready"}, 64'(lsu_bus.req_ready), 64'(v.exp_lsu));
        step();
        ifu_bus.req_valid = 1'b0;
        lsu_bus.req_valid = 1'b0;
        @(negedge clk);
        chk({p, "_mem_req_valid"}, 64'(mem_bus.req_valid), 64'd1);
        chk({p, "_mem_addr"},      64'(mem_bus.addr),      64'(v.exp_addr));
        chk({p, "_mem_wen"},       64'(mem_bus.wen),       64'(v.exp_wen));
        chk({p, "_mem_wdata"},     64'(mem_bus.wdata),     64'(v.exp_wdata));
        chk({p, "_mem_mask"},      64'(mem_bus.mask),      64'(v.exp_mask));
        chk({p, "_busy_req"},      64'(busy),              64'd1);
        step();
        @(negedge clk);
        chk({p, "_mem_resp_ready"}, 64'(mem_bus.resp_ready), 64'd1);
        chk({p, "_mem_req_valid_wait"}, 64'(mem_bus.req_valid), 64'd0);
        step();
        @(negedge clk);
        chk({p, "_ifu_resp_valid"}, 64'(ifu_bus.resp_valid), 64'(!v.exp_lsu));
        chk({p, "_lsu_resp_valid"}, 64'(lsu_bus.resp_valid), 64'(v.exp_lsu));
        chk({p, "_rdata"}, 64'(v.exp_lsu ? lsu_bus.rdata : ifu_bus.rdata), 64'(v.exp_rdata));
        step();
        @(negedge clk);
        chk({p, "_busy_done"}, 64'(busy), 64'd0);
        chk({p, "_resp_cleared"}, 64'({ifu_bus.resp_valid, lsu_bus.resp_valid}), 64'd0);
        step();
    endtask

    function automatic vec_t mk(input logic iv, input logic lv, input logic [31:0] ia,
                                input logic [31:0] la, input logic lw, input logic [31:0] lwd,
                                input logic [7:0] lm, input logic [31:0] mr, input logic el,
                                input logic [31:0] ea, input logic ew, input logic [31:0] ewd,
                                input logic [7:0] em, input logic [31:0] er);
        vec_t v;
        v.ifu_v = iv;      v.lsu_v = lv;      v.ifu_addr = ia;   v.lsu_addr = la;
        v.lsu_wen = lw;    v.lsu_wdata = lwd; v.lsu_mask = lm;   v.mem_rdata = mr;
        v.exp_lsu = el;    v.exp_addr = ea;   v.exp_wen = ew;    v.exp_wdata = ewd;
        v.exp_mask = em;   v.exp_rdata = er;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 8'h00, 32'h0000_0413,
                     0, 32'h8000_0000, 0, 32'h0, `MEM_MASK_32, 32'h0000_0413);
        vecs[1] = mk(0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, `MEM_MASK_32, 32'h1234_5678,
                     1, 32'h8000_1000, 1, 32'hDEAD_BEEF, `MEM_MASK_32, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
        vecs[2] = mk(1, 1, 32'h8000_0004, 32'h8000_2000, 0, 32'h1111_1111, `MEM_MASK_16, 32'h0000_BEEF,
                     0, 32'h8000_0004, 0, 32'h0, `MEM_MASK_32, 32'h0000_BEEF);
        vecs[4] = mk(1, 1, 32'h8000_000C, 32'h8000_2008, 0, 32'h0, `MEM_MASK_32, 32'h55AA_55AA,
                     0, 32'h8000_000C, 0, 32'h0, `MEM_MASK_32, 32'h55AA_55AA);
`else
        vecs[2] = mk(1, 1, 32'h8000_0004, 32'h8000_2000, 0, 32'h1111_1111, `MEM_MASK_16, 32'h0000_BEEF,
                     1, 32'h8000_2000, 0, 32'h1111_1111, `MEM_MASK_16, 32'h0000_BEEF);
        vecs[4] = mk(1, 1, 32'h8000_000C, 32'h8000_2008, 0, 32'h0, `MEM_MASK_32, 32'h55AA_55AA,
                     1, 32'h8000_2008, 0, 32'h0, `MEM_MASK_32, 32'h55AA_55AA);
`endif
        vecs[3] = mk(1, 1, 32'h8000_0008, 32'h8000_2004, 1, 32'hCAFE_F00D, `MEM_MASK_8, 32'hAAAA_AAAA,
                     1, 32'h8000_2004, 1, 32'hCAFE_F00D, `MEM_MASK_8, 32'h0);
        vecs[5] = mk(1, 1, 32'h8000_0010, 32'h8000_200C, 1, 32'h0102_0304, `MEM_MASK_16, 32'h7777_7777,
                     1, 32'h8000_200C, 1, 32'h0102_0304, `MEM_MASK_16, 32'h0);
        vecs[6] = mk(1, 0, 32'h8000_0400, 32'h0, 0, 32'h0, 8'h00, 32'h0010_0073,
                     0, 32'h8000_0400, 0, 32'h0, `MEM_MASK_32, 32'h0010_0073);

        // IFU write-side fields are garbage on purpose; the arbiter must substitute its own.
        ifu_bus.req_valid  = 1'b1;
        ifu_bus.addr       = '0;
        ifu_bus.wen        = 1'b1;
        ifu_bus.wdata      = 32'hFFFF_FFFF;
        ifu_bus.mask       = 8'hFF;
        ifu_bus.resp_ready = 1'b1;
        lsu_bus.req_valid  = 1'b0;
        lsu_bus.addr       = '0;
        lsu_bus.wen        = 1'b0;
        lsu_bus.wdata      = '0;
        lsu_bus.mask       = '0;
        lsu_bus.resp_ready = 1'b1;
        mem_bus.req_ready  = 1'b1;
        mem_bus.resp_valid = 1'b1;
        mem_bus.rdata      = '0;

        #3;
        chk("rst_busy",          64'(busy),               64'd0);
        chk("rst_ifu_req_ready", 64'(ifu_bus.req_ready),  64'd0);
        chk("rst_mem_req_valid", 64'(mem_bus.req_valid),  64'd0);
        chk("rst_mem_addr",      64'(mem_bus.addr),       64'd0);
        chk("rst_resp_valids",   64'({ifu_bus.resp_valid, lsu_bus.resp_valid}), 64'd0);
        ifu_bus.req_valid = 1'b0;
        #9 rst = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Memory stalls: request ignored for 5 cycles, response late by 3.
        mem_bus.req_ready  = 1'b0;
        mem_bus.resp_valid = 1'b0;
        mem_bus.rdata      = 32'h0BAD_F00D;
        ifu_bus.req_valid  = 1'b1;
        ifu_bus.addr       = 32'h8000_0100;
        @(negedge clk);
        chk("stall_ifu_accept", 64'(ifu_bus.req_ready), 64'd1);
        step();
        ifu_bus.req_valid = 1'b0;
        ifu_bus.addr      = 32'hFFFF_0000;
        lsu_bus.req_valid = 1'b1;
        lsu_bus.addr      = 32'h8000_5000;
        lsu_bus.wen       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall_req_valid_%0d", i), 64'(mem_bus.req_valid), 64'd1);
            chk($sformatf("stall_addr_%0d", i),      64'(mem_bus.addr),      64'h8000_0100);
            chk($sformatf("stall_wen_%0d", i),       64'(mem_bus.wen),       64'd0);
            chk($sformatf("stall_lsu_ready_%0d", i), 64'(lsu_bus.req_ready), 64'd0);
            step();
        end
        mem_bus.req_ready = 1'b1;
        @(negedge clk);
        chk("stall_req_valid_last", 64'(mem_bus.req_valid), 64'd1);
        step();
        mem_bus.req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("late_resp_ready_%0d", i), 64'(mem_bus.resp_ready), 64'd1);
            chk($sformatf("late_ifu_resp_%0d", i),   64'(ifu_bus.resp_valid), 64'd0);
            chk($sformatf("late_lsu_ready_%0d", i),  64'(lsu_bus.req_ready),  64'd0);
            step();
        end
        mem_bus.resp_valid = 1'b1;
        step();
        mem_bus.resp_valid = 1'b0;
        lsu_bus.req_valid  = 1'b0;
        mem_bus.rdata      = 32'h0;
        @(negedge clk);
        chk("late_ifu_resp_valid", 64'(ifu_bus.resp_valid), 64'd1);
        chk("late_ifu_rdata",      64'(ifu_bus.rdata),      64'h0BAD_F00D);
        chk("late_lsu_resp_valid", 64'(lsu_bus.resp_valid), 64'd0);
        step();
        @(negedge clk);
        chk("late_resp_once", 64'(ifu_bus.resp_valid), 64'd0);
        chk("late_idle",      64'(busy),               64'd0);
        step();

        // LSU holds off its response for 4 cycles while IFU waits.
        mem_bus.req_ready  = 1'b1;
        mem_bus.resp_valid = 1'b1;
        mem_bus.rdata      = 32'h1357_9BDF;
        lsu_bus.req_valid  = 1'b1;
        lsu_bus.addr       = 32'h8000_3000;
        lsu_bus.wen        = 1'b0;
        lsu_bus.mask       = `MEM_MASK_32;
        lsu_bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_lsu_accept", 64'(lsu_bus.req_ready), 64'd1);
        step();
        lsu_bus.req_valid = 1'b0;
        step();
        step();
        ifu_bus.req_valid = 1'b1;
        ifu_bus.addr      = 32'h8000_0200;
        mem_bus.rdata     = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp_lsu_resp_valid_%0d", i), 64'(lsu_bus.resp_valid), 64'd1);
            chk($sformatf("bp_lsu_rdata_%0d", i),      64'(lsu_bus.rdata),      64'h1357_9BDF);
            chk($sformatf("bp_busy_%0d", i),           64'(busy),               64'd1);
            chk($sformatf("bp_ifu_ready_%0d", i),      64'(ifu_bus.req_ready),  64'd0);
            step();
        end
        ifu_bus.req_valid  = 1'b0;
        lsu_bus.resp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_consumed", 64'({busy, lsu_bus.resp_valid}), 64'd0);
        step();

        // Asynchronous reset while waiting for the memory response.
        mem_bus.resp_valid = 1'b0;
        ifu_bus.req_valid  = 1'b1;
        ifu_bus.addr       = 32'h8000_0300;
        step();
        ifu_bus.addr = 32'h8000_0304;
        step();
        @(negedge clk);
        chk("arst_pre_wait", 64'(mem_bus.resp_ready), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_resp_ready", 64'(mem_bus.resp_ready), 64'd0);
        chk("arst_busy",       64'(busy),               64'd0);
        chk("arst_req_valid",  64'(mem_bus.req_valid),  64'd0);
        chk("arst_ifu_ready",  64'(ifu_bus.req_ready),  64'd0);
        chk("arst_mem_addr",   64'(mem_bus.addr),       64'd0);
        ifu_bus.req_valid  = 1'b0;
        mem_bus.resp_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        step();
        run_vec(6, vecs[6]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
